// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the request arbiters.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational priority pick: rotate the request vector by start_id, take the
// highest set index, then rotate the result back. With rr_en=0 the rotation is
// zero, giving plain highest-index-wins.
module arb_prio_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start_id,
  input  logic             rr_en,
  output logic             pick_valid,
  output logic [ID_W-1:0]  pick_id,
  output logic [N_REQ-1:0] pick_onehot
);

  logic [ID_W-1:0]    shift;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    rot_id;

  // Rotate, encode highest set bit, rotate the index back (mod N_REQ via wrap).
  always_comb begin
    shift  = rr_en ? start_id : '0;
    dbl    = {req, req} >> shift;
    rot    = dbl[N_REQ-1:0];
    rot_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rot[i]) rot_id = ID_W'(i);
    end
    pick_valid  = |rot;
    pick_id     = pick_valid ? (rot_id + shift) : '0;
    pick_onehot = pick_valid ? (N_REQ'(1) << pick_id) : '0;
  end

endmodule

// File: rtl/prio_arbiter_4.sv
// Four-requester sequencing arbiter. IDLE picks a winner, GRANT holds a
// registered one-hot grant until done, request drop or hold timeout, and
// RELEASE inserts one mandatory empty cycle before the next decision.
module prio_arbiter_4
  import arb_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 0,
  parameter int unsigned MAX_HOLD    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  // Unused when HOLD_EN is clear, so the wrap for MAX_HOLD=0 is harmless.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam bit               RR_EN     = (ROUND_ROBIN != 0);

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  last_id_q, last_id_d;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  logic [N_REQ-1:0] pick_onehot;
  logic             holder_req;
  logic             hold_hit;
  logic             normal_exit;

  arb_prio_pick u_pick (
    .req         (req),
    .start_id    (last_id_q),
    .rr_en       (RR_EN),
    .pick_valid  (pick_valid),
    .pick_id     (pick_id),
    .pick_onehot (pick_onehot)
  );

  assign holder_req  = req[gnt_id_q];
  assign hold_hit    = HOLD_EN && (cnt_q == HOLD_LAST);
  assign normal_exit = done || !holder_req;

  // Next-state and registered-output logic for the grant sequencer.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    cnt_d       = cnt_q;
    last_id_d   = last_id_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && pick_valid) begin
          gnt_d       = pick_onehot;
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (normal_exit || hold_hit) begin
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          last_id_d   = gnt_id_q;
          // A coincident done or request drop counts as a normal release.
          timeout_d   = hold_hit && !normal_exit;
          state_d     = ST_RELEASE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      last_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      last_id_q   <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_prio_arbiter_4.sv
// Bench for prio_arbiter_4: a fixed-priority instance (MAX_HOLD=4) and a
// round-robin instance (MAX_HOLD=15) share stimulus; each is compared every
// cycle against a behavioural model, plus directed spot checks.
module tb_prio_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       done;
  logic [3:0] req;

  logic [3:0] gnt_f, gnt_r;
  logic [1:0] id_f, id_r;
  logic       gv_f, gv_r;
  logic       to_f, to_r;

  int total = 0;
  int bad   = 0;

  // Model state per instance (0 = fixed/MAX_HOLD 4, 1 = round-robin/MAX_HOLD 15).
  int ph[2];    // 0 idle, 1 granted, 2 gap
  int hold[2];  // current holder
  int held[2];  // cycles the grant has been visible
  int last[2];  // last released id
  bit tmo[2];

  prio_arbiter_4 #(.ROUND_ROBIN(0), .MAX_HOLD(4)) dut_fix (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt_f),
    .gnt_id    (id_f),
    .gnt_valid (gv_f),
    .timeout   (to_f)
  );

  prio_arbiter_4 #(.ROUND_ROBIN(1), .MAX_HOLD(15)) dut_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt_r),
    .gnt_id    (id_r),
    .gnt_valid (gv_r),
    .timeout   (to_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int max_hold(input int m);
    return (m == 0) ? 4 : 15;
  endfunction

  // Fixed: highest index first. Round-robin: L-1, L-2, L-3, L (mod 4).
  function automatic int pick(input int m, input logic [3:0] r);
    if (m == 0) begin
      for (int i = 3; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (last[m] - k + 8) % 4;
        if (r[idx]) return idx;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ph[m] = 0; hold[m] = 0; held[m] = 0; last[m] = 0; tmo[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit nt;
      nt = 1'b0;
      case (ph[m])
        0: if (en && req != 4'b0) begin
          hold[m] = pick(m, req); held[m] = 1; ph[m] = 1;
        end
        1: begin
          if (done || !req[hold[m]]) begin
            ph[m] = 2; last[m] = hold[m];
          end else if (held[m] == max_hold(m)) begin
            ph[m] = 2; last[m] = hold[m]; nt = 1'b1;
          end else begin
            held[m]++;
          end
        end
        default: ph[m] = 0;
      endcase
      tmo[m] = nt;
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int m);
    return (ph[m] == 1) ? 4'(1 << hold[m]) : 4'd0;
  endfunction

  function automatic logic [1:0] exp_id(input int m);
    return (ph[m] == 1) ? 2'(hold[m]) : 2'd0;
  endfunction

  task automatic check_all();
    chk("gnt_f", 8'(gnt_f), 8'(exp_gnt(0)));
    chk("id_f",  8'(id_f),  8'(exp_id(0)));
    chk("gv_f",  8'(gv_f),  8'(ph[0] == 1));
    chk("to_f",  8'(to_f),  8'(tmo[0]));
    chk("gnt_r", 8'(gnt_r), 8'(exp_gnt(1)));
    chk("id_r",  8'(id_r),  8'(exp_id(1)));
    chk("gv_r",  8'(gv_r),  8'(ph[1] == 1));
    chk("to_r",  8'(to_r),  8'(tmo[1]));
  endtask

  // One clock: model advances at the edge, outputs checked at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; req = 4'b0; done = 1'b0;
    @(negedge clk);
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  int hi;
  int w;
  logic [1:0] rr_exp[5];

  initial begin
    rst_n = 1'b0; en = 1'b0; req = 4'b0; done = 1'b0;
    @(negedge clk);
    do_reset();

    // Fixed priority: 1010 -> 1000, done, regrant after two low cycles.
    en = 1'b1; req = 4'b1010;
    cycle();
    chk("fix_gnt", 8'(gnt_f), 8'h08);
    chk("fix_id", 8'(id_f), 8'h03);
    done = 1'b1; cycle(); done = 1'b0;
    chk("fix_rel", 8'(gnt_f), 8'h00);
    cycle();
    chk("fix_gap", 8'(gnt_f), 8'h00);
    cycle();
    chk("fix_regnt", 8'(gnt_f), 8'h08);

    // Round-robin rotation with all requests held.
    do_reset();
    rr_exp[0] = 2'd3; rr_exp[1] = 2'd2; rr_exp[2] = 2'd1; rr_exp[3] = 2'd0; rr_exp[4] = 2'd3;
    en = 1'b1; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (!gv_r && w < 10) begin cycle(); w++; end
      chk("rr_wait", 8'(w < 10), 8'h01);
      chk("rr_id", 8'(id_r), 8'(rr_exp[k]));
      if (k > 0) chk("rr_gap", 8'(w), 8'h02);
      done = 1'b1; cycle(); done = 1'b0;
    end

    // Timeout after 4 visible cycles on the fixed instance.
    do_reset();
    en = 1'b1; req = 4'b0001;
    cycle();
    hi = 1;
    while (gv_f && hi < 20) begin cycle(); if (gv_f) hi++; end
    chk("to_len", 8'(hi), 8'h04);
    chk("to_pulse", 8'(to_f), 8'h01);
    cycle();
    chk("to_clear", 8'(to_f), 8'h00);
    cycle();
    chk("to_regnt", 8'(gnt_f), 8'h01);

    // done on the would-be timeout edge: normal release.
    do_reset();
    en = 1'b1; req = 4'b0001;
    cycle(); cycle(); cycle(); cycle();
    done = 1'b1; cycle(); done = 1'b0;
    chk("to_done", 8'(to_f), 8'h00);
    chk("to_done_gnt", 8'(gnt_f), 8'h00);

    // en gating, en drop mid-grant, non-holder toggling, holder drop.
    do_reset();
    en = 1'b0; req = 4'b0100;
    repeat (3) cycle();
    chk("en_off", 8'(gv_f), 8'h00);
    en = 1'b1; cycle();
    chk("en_on", 8'(gnt_f), 8'h04);
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req = 4'b0100 | (4'($urandom) & 4'b1011);
      cycle();
      chk("hold_f", 8'(gnt_f), 8'h04);
    end
    req = 4'b0000; cycle();
    chk("drop", 8'(gnt_f), 8'h00);

    // Async reset mid-grant; round-robin order restarts at 3.
    do_reset();
    en = 1'b1; req = 4'b1111;
    cycle();
    done = 1'b1; cycle(); done = 1'b0;
    cycle(); cycle();
    chk("rr_pre", 8'(id_r), 8'h02);
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("ar_gnt", 8'(gnt_r), 8'h00);
    chk("ar_id", 8'(id_r), 8'h00);
    chk("ar_gv", 8'(gv_f), 8'h00);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("rr_post", 8'(id_r), 8'h03);

    // Empty request vector.
    do_reset();
    en = 1'b1; req = 4'b0;
    repeat (10) cycle();
    chk("empty", 8'(gv_r), 8'h00);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 3) req = 4'($urandom);
      done = ($urandom_range(0, 99) < 12);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
